// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the serial ADC capture front end.
package adc_pkg;
  localparam int SAMPLE_W   = 12;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int BCNT_W     = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: sclk idles high, toggles every CLK_DIV clk cycles while active.
// rise_tick/fall_tick flag the clk edge that drives sclk 0->1 / 1->0.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] dcnt;
  logic          wrap;

  assign wrap      = active && (dcnt == DW'(CLK_DIV - 1));
  assign rise_tick = wrap && !sclk;
  assign fall_tick = wrap && sclk;

  always_ff @(posedge clk) begin
    if (reset || !active) begin
      dcnt <= '0;
      sclk <= 1'b1;
    end else if (wrap) begin
      dcnt <= '0;
      sclk <= ~sclk;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end
endmodule

// File: rtl/adc_spi_capture.sv
// Periodic 16-SCLK serial ADC frame capture (4 leading zeros + 12 data bits, MSB first).
// Define ADC_FRAME_CHECK_EN to build the sticky leading-zero check on frame_err.
module adc_spi_capture
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2268
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sdata,
  output logic                cs_n,
  output logic                sclk,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                busy,
  output logic                frame_err
);
  localparam int DATA_W = SAMPLE_W;
  localparam int PW     = $clog2(SAMPLE_PERIOD);

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("adc_spi_capture: CLK_DIV must be >= 2");
    end
    if (SAMPLE_PERIOD < 32 * CLK_DIV + 2) begin : g_bad_period
      $error("adc_spi_capture: SAMPLE_PERIOD must be >= 32*CLK_DIV+2");
    end
  endgenerate

  state_t              state, state_nx;
  logic [PW-1:0]       pcnt;
  logic [BCNT_W-1:0]   bcnt;
  logic                last_bit;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   sample_q;
  logic                start;
  logic                frame_end;
  logic                rise_tick;
  logic                unused_fall_tick;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk       (clk),
    .reset     (reset),
    .active    (!cs_n),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (unused_fall_tick)
  );

  assign start     = enable && (pcnt == '0);
  assign frame_end = (state == CONV) && (state_nx == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // DONE may chain straight into CONV so the minimum period is 32*CLK_DIV+2.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CONV;
      CONV:    if (last_bit) state_nx = DONE;
      DONE:    state_nx = start ? CONV : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cs_n         = (state != CONV);
  assign busy         = (state == CONV);
  assign sample_valid = (state == DONE);
  assign sample       = sample_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt     <= '0;
      bcnt     <= '0;
      last_bit <= 1'b0;
      shreg    <= '0;
      sample_q <= '0;
    end else begin
      if (!enable || pcnt == PW'(SAMPLE_PERIOD - 1)) pcnt <= '0;
      else                                           pcnt <= pcnt + 1'b1;

      // Leading zeros shift through and fall off the top of the 12-bit register.
      if (state != CONV) begin
        bcnt     <= '0;
        last_bit <= 1'b0;
      end else if (rise_tick) begin
        shreg <= {shreg[DATA_W-2:0], sdata};
        bcnt  <= bcnt + 1'b1;
        if (bcnt == BCNT_W'(FRAME_BITS - 1)) last_bit <= 1'b1;
      end

      if (frame_end) sample_q <= shreg;
    end
  end

`ifdef ADC_FRAME_CHECK_EN
  logic lead_bad;
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lead_bad <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state != CONV)
        lead_bad <= 1'b0;
      else if (rise_tick && bcnt < BCNT_W'(LEAD_ZEROS) && sdata)
        lead_bad <= 1'b1;
      if (frame_end && lead_bad) err_q <= 1'b1;
    end
  end

  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture with a behavioural 16-bit serial ADC model.
module tb_adc_spi_capture;
  import adc_pkg::*;

`ifdef ADC_FRAME_CHECK_EN
  localparam logic FE_ON = 1'b1;
`else
  localparam logic FE_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic                sdata = 1'b0;
  logic                cs_n;
  logic                sclk;
  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                busy;
  logic                frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  adc_spi_capture #(.CLK_DIV(4), .SAMPLE_PERIOD(200)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sdata        (sdata),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ADC model: word latched on cs_n fall, bit n presented on the (n+1)th sclk fall.
  logic [15:0] tx_q[$];
  logic [15:0] adc_word = '0;
  int          adc_bit  = 0;

  always @(negedge cs_n) begin
    if (tx_q.size() > 0) adc_word = tx_q.pop_front();
    else                 adc_word = 16'h0000;
    adc_bit = 0;
  end

  always @(negedge sclk) begin
    if (cs_n === 1'b0 && adc_bit < 16) begin
      sdata = adc_word[15 - adc_bit];
      adc_bit++;
    end
  end

  // sclk rising edges per cs_n low window
  logic chk_edges = 1'b0;
  int   redges    = 0;
  always @(negedge cs_n) redges = 0;
  always @(posedge sclk) if (cs_n === 1'b0) redges++;
  always @(posedge cs_n) if (chk_edges) chk("sclk_rises", redges, 16);

  task automatic wait_csn_fall(output int t);
    int n = 0;
    while (cs_n !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cs_n !== 1'b0) chk("csn_fall_timeout", 1, 0);
    t = cyc;
  endtask

  // Entered at the negedge of cycle T (first cs_n low cycle); leaves at T+130.
  task automatic frame_check(input logic [11:0] exp, input int drop_at, output int vcyc);
    int          early;
    logic [11:0] s0;
    early = 0;
    s0    = sample;
    chk("busy_T", busy, 1);
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk);
      if (sample_valid || sample !== s0 || cs_n) early++;
      if (k == drop_at) enable = 1'b0;
    end
    @(negedge clk);
    vcyc = cyc;
    chk("valid_T129", sample_valid, 1);
    chk("sample", sample, exp);
    chk("csn_T129", cs_n, 1);
    chk("busy_T129", busy, 0);
    chk("frame_early", early, 0);
    @(negedge clk);
    chk("valid_one_cycle", sample_valid, 0);
  endtask

  initial begin
    int t1, t2, t3, v1, v2, v3, vx, lows, nvld;
    logic [11:0] w;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_csn", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b0;

    // Basic frame and steady-state period
    tx_q.push_back(16'h0ABC);
    enable = 1'b1;
    wait_csn_fall(t1);
    frame_check(12'hABC, 0, v1);
    tx_q.push_back(16'h0FFF);
    wait_csn_fall(t2);
    chk("start_period", t2 - t1, 200);
    frame_check(12'hFFF, 0, v2);
    tx_q.push_back(16'h0000);
    wait_csn_fall(t3);
    chk("sample_hold", sample, 12'hFFF);
    frame_check(12'h000, 0, v3);
    chk("valid_period_1", v2 - v1, 200);
    chk("valid_period_2", v3 - v2, 200);
    chk("frame_err_clean", frame_err, 0);

    // Leading-zero violation then a good frame
    tx_q.push_back(16'h8123);
    wait_csn_fall(t1);
    chk("frame_err_before", frame_err, 0);
    frame_check(12'h123, 0, vx);
    chk("frame_err_set", frame_err, FE_ON);
    tx_q.push_back(16'h0456);
    wait_csn_fall(t1);
    frame_check(12'h456, 0, vx);
    chk("frame_err_sticky", frame_err, FE_ON);

    // enable dropped mid-frame, then re-enabled
    tx_q.push_back(16'h0321);
    wait_csn_fall(t1);
    frame_check(12'h321, 40, vx);
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (cs_n !== 1'b1) lows++;
    end
    chk("disabled_no_start", lows, 0);
    tx_q.push_back(16'h0777);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_start", cs_n, 0);
    frame_check(12'h777, 0, vx);

    // reset mid-frame discards the partial sample
    tx_q.push_back(16'h0555);
    wait_csn_fall(t1);
    repeat (50) @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("midrst_csn", cs_n, 1);
    chk("midrst_sclk", sclk, 1);
    chk("midrst_sample", sample, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", sample_valid, 0);
    reset = 1'b0;
    nvld = 0;
    repeat (200) begin
      @(negedge clk);
      if (sample_valid) nvld++;
    end
    chk("midrst_no_valid", nvld, 0);

    // Continuous stream of random words
    chk_edges = 1'b1;
    enable    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w = 12'($urandom_range(0, 4095));
      tx_q.push_back({4'h0, w});
      wait_csn_fall(t1);
      frame_check(w, 0, vx);
    end
    chk_edges = 1'b0;
    enable    = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
- Upstream source stage for the 12-bit sample delay line. It drives a 16-SCLK serial ADC frame: 4 leading zeros, then 12 data bits MSB first, in the AD7476/Pmod AD1 style.
- It deserialises each frame and presents a held 12-bit sample word with a one-cycle valid strobe.
- Conversions are started on a fixed sample period derived from clk.
- The delay line shifts every clk, so the sample output holds its value between conversions.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period (>=2).
- SAMPLE_PERIOD, 2268, clk cycles between conversion starts. Must be >= 32*CLK_DIV+2; an elaboration-time check enforces this.
- DATA_W, 12, sample width. Fixed by the package; not overridable.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run conversions while high.
- sdata  input  1  ADC serial data.
- cs_n  output  1  ADC chip select, active low.
- sclk  output  1  ADC serial clock, idle high.
- sample  output  12  last captured sample; feeds the delay-line datain.
- sample_valid  output  1  one-cycle pulse when sample updates.
- busy  output  1  high while cs_n is low.
- frame_err  output  1  sticky leading-zero violation (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. On the first clk edge with reset high: cs_n=1, sclk=1, sample=0, sample_valid=0, busy=0, frame_err=0, state=IDLE, all counters=0.
- Period counter pcnt:
  - Counts 0..SAMPLE_PERIOD-1 and wraps, only while enable=1.
  - Held at 0 while enable=0.
- States: IDLE, CONV, DONE.
- IDLE -> CONV: at an edge where enable=1 and pcnt==0. cs_n=0 and busy=1 from the next cycle; call that cycle T.
- CONV:
  - Divider dcnt counts 0..CLK_DIV-1; sclk toggles on each dcnt wrap.
  - sclk falls at T+CLK_DIV and rises at T+2*CLK_DIV, etc.
  - On each clk edge that drives sclk 0->1, sdata is captured into a bit counter (0..15) and a shift register.
  - Bits 0-3 are leading zeros; bits 4-15 shift MSB-first into the 12-bit register.
  - After the 16th rising edge (T+32*CLK_DIV) -> DONE.
- DONE (one cycle, T+32*CLK_DIV+1):
  - cs_n=1, sclk=1, busy=0.
  - sample <= shift register, sample_valid=1.
  - Next state IDLE.
  - Latency from cs_n fall to sample_valid: 32*CLK_DIV+1 cycles.
- Steady state: with enable held high, sample_valid pulses exactly SAMPLE_PERIOD cycles apart.
- sample holds its value until the next DONE. sample_valid is low in all other cycles.
- enable deasserted during CONV: the frame completes normally, including DONE and sample_valid. No new conversion starts. pcnt resets to 0.
- enable reasserted: the first conversion starts on the edge where pcnt==0, i.e. the first edge enable is seen high.
- Reset mid-frame: aborts immediately to reset values. No sample_valid; the partial frame is discarded.
- sdata is assumed already synchronous to clk (pin registered upstream in the IOB flop); no extra synchroniser.

Optional Feature:
- Macro: ADC_FRAME_CHECK_EN.
- Defined:
  - If any of bits 0-3 of a frame is 1, frame_err is set at DONE.
  - Sticky until reset.
  - sample still updates with bits 4-15.
- Undefined: frame_err is tied to 0 and no check logic is built.

Decomposition:
- Package adc_pkg:
  - SAMPLE_W=12, FRAME_BITS=16, LEAD_ZEROS=4.
  - State enum {IDLE, CONV, DONE}.
  - Bit-counter width constant $clog2(FRAME_BITS).
- Sub-module spi_sclk_gen:
  - Holds the dcnt divider and sclk register.
  - Outputs rise_tick/fall_tick strobes.
  - Cleared while cs_n=1.
- Top level holds the FSM, pcnt, shift register and output registers.

Test Plan:
- Setup: CLK_DIV=4, SAMPLE_PERIOD=200. The bench ADC model shifts word 0x0ABC MSB-first, changing sdata on sclk falls.
  -> cs_n low at T, sample=0xABC and sample_valid=1 at T+129 only, cs_n=1 at T+129.
- Words 0x0FFF then 0x0000 on consecutive frames.
  -> sample=0xFFF, then 0x000. sample_valid pulses 200 cycles apart. sample holds between pulses.
- Word 0x8123:
  - With ADC_FRAME_CHECK_EN: sample=0x123 and frame_err=1, staying 1 across a following good frame 0x0456.
  - Without the macro: frame_err stays 0.
- enable dropped at T+40 of a frame.
  -> the frame completes with valid at T+129, then no cs_n fall for 400 cycles.
  - Re-enable: cs_n falls one cycle after the first edge enable is seen high.
- reset pulsed at T+50 mid-frame.
  -> next cycle cs_n=1, sclk=1, sample=0, busy=0. No sample_valid for that frame.
- Continuous run of 20 random 12-bit words.
  -> captured stream equals the sent stream in order, and sclk shows exactly 16 rising edges per cs_n low window.
